// File: rtl/testcore_nios2_gen2_div_pkg.sv
// Shared types and constants for the iterative divide cell.
package testcore_nios2_gen2_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } div_state_e;

endpackage

// File: rtl/testcore_nios2_gen2_f_div_step.sv
// One restoring radix-2 divide step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only if it did not borrow.
module testcore_nios2_gen2_f_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quot_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quot_out
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             fits;

  assign shifted  = {rem_in[WIDTH-1:0], quot_in[WIDTH-1]};
  // The extra top bit of the difference is the borrow of the trial subtract.
  assign diff     = {rem_in[WIDTH], shifted} - {2'b00, divisor};
  assign fits     = ~diff[WIDTH+1];
  assign rem_out  = fits ? diff[WIDTH:0] : shifted;
  assign quot_out = {quot_in[WIDTH-2:0], fits};

endmodule

// File: rtl/testcore_nios2_gen2_f_div_cell.sv
// Multi-cycle signed/unsigned restoring divider (IDLE -> PREP -> ITER x WIDTH -> FIX).
// Define TESTCORE_DIV_REMAINDER_EN to produce the remainder; otherwise A_div_rem is 0.
module testcore_nios2_gen2_f_div_cell
  import testcore_nios2_gen2_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             E_div_start,
  input  logic             E_ctrl_div_signed,
  input  logic [WIDTH-1:0] E_src1_div_cell,
  input  logic [WIDTH-1:0] E_src2_div_cell,
  input  logic             A_kill,
  output logic             A_div_busy,
  output logic             A_div_done,
  output logic [WIDTH-1:0] A_div_quot,
  output logic [WIDTH-1:0] A_div_rem
);

  div_state_e           state, state_nxt;
  logic [DIV_CNT_W-1:0] cnt;
  logic                 div_signed;
  logic                 quot_neg;
  logic [WIDTH-1:0]     q_work, d_work;
  logic [WIDTH:0]       r_work;
  logic [WIDTH:0]       r_step;
  logic [WIDTH-1:0]     q_step;
  logic                 last_step;
  logic [WIDTH-1:0]     quot_q;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  testcore_nios2_gen2_f_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (r_work),
    .quot_in (q_work),
    .divisor (d_work),
    .rem_out (r_step),
    .quot_out(q_step)
  );

  assign last_step = (state == ITER) && (cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (E_div_start) state_nxt = PREP;
      PREP:    state_nxt = ITER;
      ITER:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (A_kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      div_signed <= 1'b0;
      quot_neg   <= 1'b0;
      q_work     <= '0;
      d_work     <= '0;
      r_work     <= '0;
    end else begin
      case (state)
        IDLE: if (E_div_start && !A_kill) begin
          div_signed <= E_ctrl_div_signed;
          q_work     <= E_src1_div_cell;
          d_work     <= E_src2_div_cell;
        end
        PREP: begin
          q_work   <= mag(q_work, div_signed);
          d_work   <= mag(d_work, div_signed);
          r_work   <= '0;
          cnt      <= DIV_CNT_W'(WIDTH - 1);
          // Divide by zero keeps the all-ones quotient unnegated.
          quot_neg <= div_signed && (q_work[WIDTH-1] ^ d_work[WIDTH-1]) && (|d_work);
        end
        ITER: begin
          q_work <= q_step;
          r_work <= r_step;
          if (cnt != '0) cnt <= cnt - DIV_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Results are sign-corrected as the last step lands, so they are valid during FIX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 quot_q <= '0;
    else if (last_step && !A_kill) quot_q <= quot_neg ? -q_step : q_step;
  end

`ifdef TESTCORE_DIV_REMAINDER_EN
  logic             rem_neg;
  logic [WIDTH-1:0] rem_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_neg <= 1'b0;
      rem_q   <= '0;
    end else begin
      if (state == PREP) rem_neg <= div_signed && q_work[WIDTH-1];
      if (last_step && !A_kill)
        rem_q <= rem_neg ? -r_step[WIDTH-1:0] : r_step[WIDTH-1:0];
    end
  end

  assign A_div_rem = rem_q;
`else
  assign A_div_rem = '0;
`endif

  assign A_div_quot = quot_q;
  assign A_div_busy = (state != IDLE);
  assign A_div_done = (state == FIX);

endmodule

// File: tb/tb_testcore_nios2_gen2_f_div_cell.sv
// Directed bench for the divide cell: vector table plus kill, reset and held-start sequences.
module tb_testcore_nios2_gen2_f_div_cell;

`ifdef TESTCORE_DIV_REMAINDER_EN
  localparam logic REM_EN = 1'b1;
`else
  localparam logic REM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        E_div_start = 1'b0;
  logic        E_ctrl_div_signed = 1'b0;
  logic [31:0] E_src1_div_cell = '0;
  logic [31:0] E_src2_div_cell = '0;
  logic        A_kill = 1'b0;
  logic        A_div_busy, A_div_done;
  logic [31:0] A_div_quot, A_div_rem;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a, b, q, r;
  } vec_t;

  vec_t vecs[11];

  testcore_nios2_gen2_f_div_cell #(.WIDTH(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .E_div_start      (E_div_start),
    .E_ctrl_div_signed(E_ctrl_div_signed),
    .E_src1_div_cell  (E_src1_div_cell),
    .E_src2_div_cell  (E_src2_div_cell),
    .A_kill           (A_kill),
    .A_div_busy       (A_div_busy),
    .A_div_done       (A_div_done),
    .A_div_quot       (A_div_quot),
    .A_div_rem        (A_div_rem)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rem_exp(input logic [31:0] r);
    return r & {32{REM_EN}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    E_ctrl_div_signed = sgn;
    E_src1_div_cell   = a;
    E_src2_div_cell   = b;
    E_div_start       = 1'b1;
  endtask

  // Called at the negedge of the launch cycle; returns the cycle index of done, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 0; c < 100; c++) begin
      if (A_div_done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
      E_div_start = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int          lat;
    int          done_cnt;
    int          done_cyc[2];
    logic        done_seen;
    logic [31:0] prev_q, prev_r;

    vecs[0]  = '{"u_100_7",      1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{"s_m100_7",     1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE};
    vecs[2]  = '{"s_100_m7",     1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2};
    vecs[3]  = '{"u_5_0",        1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    vecs[4]  = '{"s_5_0",        1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    vecs[5]  = '{"s_min_m1",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[6]  = '{"u_min_m1",     1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[7]  = '{"s_m5_0",       1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};
    vecs[8]  = '{"s_m100_m7",    1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
    vecs[9]  = '{"u_7_100",      1'b0, 32'd7,          32'd100,        32'd0,          32'd7};
    vecs[10] = '{"u_max_1",      1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};

    // Reset state
    #12;
    check("rst_busy", {31'd0, A_div_busy}, 32'd0);
    check("rst_done", {31'd0, A_div_done}, 32'd0);
    check("rst_quot", A_div_quot, 32'd0);
    check("rst_rem",  A_div_rem,  32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
      @(negedge clk);
      wait_done(lat);
      check({vecs[i].name, "_lat"},  lat,        32'd34);
      check({vecs[i].name, "_quot"}, A_div_quot, vecs[i].q);
      check({vecs[i].name, "_rem"},  A_div_rem,  rem_exp(vecs[i].r));
    end
    prev_q = vecs[10].q;
    prev_r = rem_exp(vecs[10].r);

    // Kill in cycle 10 (start also high: kill wins), restart in cycle 11
    @(posedge clk); #1;
    launch(1'b0, 32'd100, 32'd7);
    done_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (A_div_done) done_seen = 1'b1;
      @(posedge clk); #1;
      E_div_start = 1'b0;
    end
    A_kill = 1'b1;
    E_div_start = 1'b1;
    @(negedge clk);
    if (A_div_done) done_seen = 1'b1;
    @(posedge clk); #1;
    A_kill = 1'b0;
    launch(1'b0, 32'd200, 32'd3);
    @(negedge clk);
    check("kill_busy",     {31'd0, A_div_busy}, 32'd0);
    check("kill_no_done",  {31'd0, done_seen},  32'd0);
    check("kill_quot_hold", A_div_quot, prev_q);
    check("kill_rem_hold",  A_div_rem,  prev_r);
    wait_done(lat);
    check("kill_restart_cyc", 32'(11 + lat), 32'd45);
    check("kill_restart_quot", A_div_quot, 32'd66);
    check("kill_restart_rem",  A_div_rem,  rem_exp(32'd2));

    // Kill together with start in IDLE stays idle
    @(posedge clk); #1;
    A_kill = 1'b1;
    launch(1'b0, 32'd9, 32'd2);
    @(posedge clk); #1;
    A_kill = 1'b0;
    E_div_start = 1'b0;
    @(negedge clk);
    check("kill_start_idle", {31'd0, A_div_busy}, 32'd0);

    // Start held high: done cycle ignores it, following IDLE cycle accepts it
    @(posedge clk); #1;
    launch(1'b0, 32'd1000, 32'd9);
    done_cnt = 0;
    done_cyc[0] = -1;
    done_cyc[1] = -1;
    for (int c = 0; c <= 80; c++) begin
      @(negedge clk);
      if (A_div_done) begin
        if (done_cnt < 2) done_cyc[done_cnt] = c;
        done_cnt++;
      end
      if (c == 35) check("held_busy_c35", {31'd0, A_div_busy}, 32'd0);
      @(posedge clk); #1;
    end
    E_div_start = 1'b0;
    check("held_done_cnt",  done_cnt,    32'd2);
    check("held_done1_cyc", done_cyc[0], 32'd34);
    check("held_done2_cyc", done_cyc[1], 32'd69);
    check("held_quot",      A_div_quot,  32'd111);
    check("held_rem",       A_div_rem,   rem_exp(32'd1));
    A_kill = 1'b1;
    @(posedge clk); #1;
    A_kill = 1'b0;

    // Reset in cycle 20 of an operation, then restart right after release
    @(posedge clk); #1;
    launch(1'b0, 32'd100, 32'd7);
    done_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (A_div_done) done_seen = 1'b1;
      @(posedge clk); #1;
      E_div_start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("mrst_busy", {31'd0, A_div_busy}, 32'd0);
    check("mrst_done", {31'd0, A_div_done}, 32'd0);
    check("mrst_quot", A_div_quot, 32'd0);
    check("mrst_rem",  A_div_rem,  32'd0);
    check("mrst_no_done", {31'd0, done_seen}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    launch(1'b0, 32'd100, 32'd7);
    @(negedge clk);
    wait_done(lat);
    check("mrst_restart_lat",  lat,        32'd34);
    check("mrst_restart_quot", A_div_quot, 32'd14);
    check("mrst_restart_rem",  A_div_rem,  rem_exp(32'd2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/testcore_nios2_gen2_f_div_cell.md
TESTCORE_NIOS2_GEN2_F_DIV_CELL -- requirements
Module: testcore_nios2_gen2_f_div_cell

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, quotient and remainder width.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port E_div_start, input, 1: start request, sampled only in IDLE.
REQ-005 SHALL have port E_ctrl_div_signed, input, 1: 1 = signed divide, 0 = unsigned; captured at start.
REQ-006 SHALL have port E_src1_div_cell, input, WIDTH: dividend; captured at start.
REQ-007 SHALL have port E_src2_div_cell, input, WIDTH: divisor; captured at start.
REQ-008 SHALL have port A_kill, input, 1: pipeline flush; aborts any operation in progress.
REQ-009 SHALL have port A_div_busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have port A_div_done, output, 1: one-cycle pulse when results are valid.
REQ-011 SHALL have port A_div_quot, output, WIDTH: quotient; held until the next done.
REQ-012 SHALL have port A_div_rem, output, WIDTH: remainder; held until the next done.

Function
REQ-013 SHALL implement states IDLE, PREP, ITER, FIX.
- IDLE->PREP on start.
- PREP->ITER after one cycle.
- ITER->FIX after WIDTH cycles.
- FIX->IDLE after one cycle.
REQ-014 In PREP, SHALL form the magnitudes of both operands when signed, and record the quotient sign (sign1 XOR sign2) and the remainder sign (sign1).
REQ-015 In ITER, SHALL perform one restoring radix-2 step per cycle using a WIDTH+1-bit partial remainder, with a 6-bit iteration counter counting WIDTH-1 down to 0.
REQ-016 In FIX, SHALL apply sign correction, register the quotient and remainder, and assert A_div_done for exactly that cycle.
- Latency: start sampled in cycle 0 -> done in cycle WIDTH+2.
REQ-017 SHALL ignore E_div_start while busy, and SHALL NOT re-sample the operands.
REQ-018 A start in the same cycle as a done pulse SHALL be ignored; a start in the following cycle (IDLE) SHALL be accepted.
REQ-019 Divisor zero SHALL give quotient all-ones and remainder equal to the dividend, in both signed and unsigned modes, with unchanged latency.
REQ-020 A signed most-negative dividend divided by -1 SHALL give quotient equal to the most-negative value and remainder 0, with no exception.
REQ-021 The remainder SHALL carry the sign of the dividend, and quotient*divisor+remainder SHALL equal the dividend modulo 2^WIDTH.
REQ-022 A_kill SHALL force IDLE on the next edge from any state.
- A_kill suppresses done.
- A_kill leaves A_div_quot and A_div_rem unchanged.
- A_kill takes priority over a simultaneous start.

Reset
REQ-023 Asserting reset_n low SHALL immediately force IDLE, A_div_busy=0, A_div_done=0, A_div_quot=0, A_div_rem=0, and the counter and datapath registers to 0.
REQ-024 Reset mid-operation SHALL discard the operation with no done pulse; the first edge after deassertion SHALL sample start normally.

Configuration
REQ-025 Macro TESTCORE_DIV_REMAINDER_EN defined: A_div_rem SHALL carry the sign-corrected remainder.
REQ-026 Macro TESTCORE_DIV_REMAINDER_EN undefined: A_div_rem SHALL be tied to 0, the remainder sign fixup logic SHALL be omitted, and quotient behaviour and latency SHALL be identical to the defined case.

Structure
REQ-027 Package testcore_nios2_gen2_div_pkg SHALL hold the state enum (IDLE, PREP, ITER, FIX), the default width constant of 32, and the counter width constant of 6.
REQ-028 The single restoring step (trial subtract, select, quotient bit shift) SHALL be sub-module testcore_nios2_gen2_f_div_step.
- The step SHALL be combinational.
- The step SHALL be instantiated once in the cell.

Verification
REQ-029 Unsigned 100/7, start in cycle 0 -> done in cycle 34, quot=14, rem=2.
REQ-030 Signed -100/7 -> quot=0xFFFFFFF2, rem=0xFFFFFFFE; signed 100/-7 -> quot=0xFFFFFFF2, rem=2.
REQ-031 5/0 unsigned and signed -> quot=0xFFFFFFFF, rem=5, done in cycle 34.
REQ-032 Signed 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0; unsigned same operands -> quot=0, rem=0x80000000.
REQ-033 A_kill in cycle 10 of an operation -> no done, busy=0 in cycle 11, previous results held; new start in cycle 11 -> done in cycle 45.
REQ-034 reset_n low in cycle 20 -> all outputs 0 immediately; start held high through the busy period -> exactly one done per accepted start.
